// File: rtl/vperm_xbar.sv
// vperm_xbar: registered N-lane complex crossbar with a
// double-buffered routing table and drain-before-swap commit.
module vperm_xbar #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_lane,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic                cfg_zero,
    input  logic                cfg_commit,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_data  [N-1:0],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_data [N-1:0]
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWAP
    } state_t;

    state_t              state;
    logic [SEL_W-1:0]    act_sel  [N-1:0];
    logic [SEL_W-1:0]    sh_sel   [N-1:0];
    logic [N-1:0]        act_zero;
    logic [N-1:0]        sh_zero;
    logic [2*DATA_W-1:0] routed   [N-1:0];
    logic                accept;

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != RUN);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            routed[i] = act_zero[i] ? '0 : in_data[act_sel[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            out_valid <= 1'b0;
            act_zero  <= '0;
            sh_zero   <= '0;
            for (int i = 0; i < N; i++) begin
                out_data[i] <= '0;
                act_sel[i]  <= SEL_W'(i);
                sh_sel[i]   <= SEL_W'(i);
            end
        end else begin
            // Shadow writes in SWAP land after the copy below
            if (cfg_we) begin
                sh_sel[cfg_lane]  <= cfg_sel;
                sh_zero[cfg_lane] <= cfg_zero;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= routed;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                RUN: begin
                    if (cfg_commit) state <= DRAIN;
                end
                DRAIN: begin
                    if (!out_valid || out_ready) state <= SWAP;
                end
                SWAP: begin
                    act_sel  <= sh_sel;
                    act_zero <= sh_zero;
                    state    <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vperm_xbar.sv
// Scoreboard bench for vperm_xbar: random tables and beats
// against a table-lookup reference model.
module tb_vperm_xbar;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    typedef logic [2*DW-1:0] lane_t;
    typedef logic [N-1:0][2*DW-1:0] beat_t;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [SW-1:0] cfg_lane;
    logic [SW-1:0] cfg_sel;
    logic          cfg_zero;
    logic          cfg_commit;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    lane_t         in_data  [N-1:0];
    logic          out_valid;
    logic          out_ready;
    lane_t         out_data [N-1:0];

    vperm_xbar #(.N(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_lane(cfg_lane),
        .cfg_sel(cfg_sel), .cfg_zero(cfg_zero),
        .cfg_commit(cfg_commit), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t sbq[$];
    int    a_sel[N];
    bit    a_zero[N];
    int    s_sel[N];
    bit    s_zero[N];
    int    bp_mode = 0;
    int    bp_k = 0;

    task automatic chk(input string name, input logic [N*2*DW-1:0] got,
                       input logic [N*2*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic beat_t pack_out();
        beat_t r;
        for (int i = 0; i < N; i++) r[i] = out_data[i];
        return r;
    endfunction

    function automatic beat_t mk(lane_t a, lane_t b, lane_t c, lane_t d);
        beat_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Reference: each output lane looks up its source in the live table
    function automatic beat_t model_route(beat_t b);
        beat_t r;
        for (int i = 0; i < N; i++) r[i] = a_zero[i] ? '0 : b[a_sel[i]];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            a_sel[i] = i; a_zero[i] = 0;
            s_sel[i] = i; s_zero[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int lane, input int sel, input bit z);
        cfg_we = 1; cfg_lane = SW'(lane); cfg_sel = SW'(sel); cfg_zero = z;
        step();
        cfg_we = 0;
        s_sel[lane] = sel; s_zero[lane] = z;
    endtask

    task automatic commit_pulse();
        cfg_commit = 1;
        step();
        cfg_commit = 0;
    endtask

    task automatic wait_idle(output int bcyc);
        bcyc = 0;
        while (busy && bcyc < 200) begin
            step();
            bcyc++;
        end
        if (busy) chk("commit_timeout", 1, 0);
        a_sel = s_sel;
        a_zero = s_zero;
    endtask

    task automatic send(input beat_t b);
        bit acc = 0;
        in_valid = 1;
        for (int i = 0; i < N; i++) in_data[i] = b[i];
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model_route(b));
                acc = 1;
            end
            step();
        end
        in_valid = 0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        bp_mode = 0;
        while (sbq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: out_ready = 1;
                1: begin
                    out_ready = (bp_k % 3 == 0);
                    bp_k++;
                end
                2: out_ready = 0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected beats on each output transfer
    initial begin
        beat_t prev;
        beat_t cur;
        bit    pstall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pstall = 0;
                continue;
            end
            cur = pack_out();
            if (pstall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", cur, prev);
            end
            if (busy) chk("busy_in_ready", in_ready, 0);
            else chk("run_in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("unexpected_beat", 1, 0);
                else chk("beat", cur, sbq.pop_front());
            end
            pstall = out_valid && !out_ready;
            prev = cur;
        end
    end

    initial begin
        beat_t b;
        int    bc;
        rst_n = 0; cfg_we = 0; cfg_lane = '0; cfg_sel = '0;
        cfg_zero = 0; cfg_commit = 0; in_valid = 0;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step();

        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", pack_out(), '0);

        send(mk(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
                64'h0000_0005_0000_0006, 64'h0000_0007_0000_0008));
        @(negedge clk);
        chk("ident_valid", out_valid, 1);
        chk("ident_data", pack_out(),
            mk(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
               64'h0000_0005_0000_0006, 64'h0000_0007_0000_0008));
        step();
        @(negedge clk);
        chk("ident_pulse_once", out_valid, 0);
        step();

        cfg_write(0, 0, 0); cfg_write(1, 2, 0);
        cfg_write(2, 1, 0); cfg_write(3, 3, 0);
        commit_pulse();
        wait_idle(bc);
        chk("bitrev_busy_cycles", bc, 2);
        send(mk(10, 11, 12, 13));
        @(negedge clk);
        chk("bitrev_data", pack_out(), mk(10, 12, 11, 13));
        step();

        cfg_write(0, 3, 0); cfg_write(1, 3, 0);
        cfg_write(2, 1, 1); cfg_write(3, 0, 0);
        commit_pulse();
        wait_idle(bc);
        send(mk(5, 6, 7, 8));
        @(negedge clk);
        chk("zero_bcast_data", pack_out(), mk(8, 8, 0, 5));
        step();

        bp_k = 0;
        bp_mode = 1;
        for (int k = 0; k < 8; k++) send(mk(100 + k, 200 + k, 300 + k, 400 + k));
        drain();

        // Stalled beat leaves with the old table, next uses the new one
        bp_mode = 2;
        step();
        send(mk(21, 22, 23, 24));
        for (int i = 0; i < N; i++) cfg_write(i, N - 1 - i, 0);
        commit_pulse();
        repeat (3) begin
            chk("stall_busy", busy, 1);
            chk("stall_in_ready", in_ready, 0);
            step();
        end
        bp_mode = 0;
        wait_idle(bc);
        send(mk(31, 32, 33, 34));
        @(negedge clk);
        chk("new_table_data", pack_out(), mk(34, 33, 32, 31));
        step();
        drain();

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                cfg_write(i, $urandom_range(0, N - 1), $urandom_range(0, 3) == 0);
            bp_mode = 0;
            commit_pulse();
            wait_idle(bc);
            bp_mode = 3;
            for (int k = 0; k < 10; k++) begin
                for (int i = 0; i < N; i++) b[i] = {$urandom, $urandom};
                send(b);
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        drain();

        // Reset in the middle of a drain
        bp_mode = 2;
        step();
        send(mk(41, 42, 43, 44));
        cfg_write(0, 3, 1);
        commit_pulse();
        step();
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        sbq.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        bp_mode = 0;
        step();
        send(mk(51, 52, 53, 54));
        @(negedge clk);
        chk("post_rst_ident", pack_out(), mk(51, 52, 53, 54));
        step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vperm_xbar.md
Name: vperm_xbar

Overview:
- Registered N-lane complex-amplitude crossbar for the QFT state-vector datapath.
- Each output lane selects any input lane or forces zero, under a double-buffered routing table.
- Valid/ready streaming on both sides; routing changes only on a drained pipeline, so no beat mixes two tables.
- Sits between amplitude memory read-out and the butterfly stage, performing qubit-swap / bit-reversal permutations per beat.

Parameters:
- N, 4: lane count, power of two, >= 2.
- DATA_W, 32: width of each real or imaginary part; a lane carries 2*DATA_W bits.
- SEL_W, $clog2(N): lane select width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_we  input  1  write one shadow-table entry this cycle.
- cfg_lane  input  SEL_W  output lane being written.
- cfg_sel  input  SEL_W  source input lane for cfg_lane.
- cfg_zero  input  1  1 = cfg_lane outputs zero, ignoring cfg_sel.
- cfg_commit  input  1  request shadow -> active table swap (pulse).
- busy  output  1  commit pending (DRAIN or SWAP state).
- in_valid  input  1  in_data valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  [2*DATA_W-1:0] x N (unpacked [N-1:0])  input lanes, {real, imag}, real in upper half.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  [2*DATA_W-1:0] x N (unpacked [N-1:0])  permuted lanes.

Behaviour:
- Reset (async assert, sync-free release):
  - out_valid=0, out_data all 0, busy=0, state RUN.
  - Active and shadow tables both identity: sel[i]=i, zero[i]=0.
- Routing: out lane i = zero[i] ? 0 : in_data[sel[i]], from the ACTIVE table.
  - Many-to-one (broadcast) is legal.
  - Width is preserved exactly: no arithmetic, no sign change.
- Pipeline: one register stage; latency 1 cycle from accepted beat to out_valid.
  - RUN: in_ready = !out_valid | out_ready (full-throughput, no bubble).
  - Output register loads on accept.
  - out_valid clears when out_ready=1 with no new accept.
  - out_data and out_valid hold stable while out_valid & !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Config writes:
  - cfg_we writes shadow[cfg_lane] = {cfg_zero, cfg_sel} in any state; the active table is unaffected.
- FSM:
  - RUN: cfg_commit=1 -> DRAIN.
  - DRAIN: in_ready=0, busy=1. When out_valid=0, or out_valid & out_ready this cycle -> SWAP.
  - SWAP: one cycle, in_ready=0, busy=1. Active table <= shadow table. -> RUN.
  - busy falls on the cycle after SWAP, when the new table is live.
- Simultaneous events:
  - cfg_we and cfg_commit in the same RUN cycle: the write lands in shadow and is included in the swap.
  - cfg_we during SWAP: the write lands in shadow after the copy, so it is not in the new active table.
  - cfg_commit while busy: ignored (no queueing).
  - Accept and commit in the same RUN cycle: the beat is accepted with the OLD table, then DRAIN.
- Reset mid-operation: a pending commit is discarded; the in-flight beat is lost; both tables return to identity.
- Out-of-range cfg_sel cannot occur for power-of-two N; no checking required.

Test Plan:
- Identity after reset:
  - Stimulus: N=4, in lanes {A0..A3} = 0x0000_0001_0000_0002 .. 0x0000_0007_0000_0008.
  - Expected: out_data equals in_data exactly 1 cycle later; out_valid pulses once.
- Bit-reversal permutation:
  - Stimulus: write sel = {0,2,1,3}, commit, wait for busy low, send lanes {10,11,12,13}.
  - Expected: out = {10,12,11,13}; busy high exactly 2 cycles with empty pipe.
- Zero and broadcast:
  - Stimulus: lane0 sel=3, lane1 sel=3, lane2 zero, lane3 sel=0; input {5,6,7,8}.
  - Expected: out = {8,8,0,5}.
- Backpressure:
  - Stimulus: stream 8 beats with out_ready toggling 1,0,0,1,...
  - Expected: no beat lost or duplicated; out_data stable while stalled; in_ready=0 exactly when out_valid & !out_ready.
- Commit under stall:
  - Stimulus: out_valid=1, out_ready=0, pulse cfg_commit.
  - Expected: busy=1 and in_ready=0 until out_ready=1; the stalled beat exits with the OLD table; the next beat uses the NEW table.
- Async reset mid-DRAIN:
  - Stimulus: assert rst_n=0 between clock edges.
  - Expected: out_valid=0 and busy=0 immediately; next beat routed as identity.
